lnrv_ifu_ibuf: RTL

Instruction queue between the fetch stage and the decode/execute stage. It accepts fetched instruction packets (pc, ir, misalign flag, bus-error flag) over a valid/ready handshake and buffers up to DEPTH of them. It presents them in order to decode over a second valid/ready handshake. Its input ready is registered, so there is no combinational path from decode stall to the fetch bus. A pipeline flush discards all buffered packets.

---
 rtl/lnrv_ifu_ibuf_pkg.sv | 26 ++
 rtl/lnrv_gnrl_fifo.sv | 72 +++++++
 rtl/lnrv_ifu_ibuf.sv | 83 ++++++++
 3 files changed

// File: rtl/lnrv_ifu_ibuf_pkg.sv
// Shared entry layout for the IFU instruction buffer: widths, field offsets
// and the pack helper used when a fetch packet enters the queue.
package lnrv_ifu_ibuf_pkg;

    localparam int LNRV_IBUF_ENTRY_W     = 66;
    localparam int LNRV_IBUF_PC_LSB      = 0;
    localparam int LNRV_IBUF_IR_LSB      = 32;
    localparam int LNRV_IBUF_MISALGN_BIT = 64;
    localparam int LNRV_IBUF_BUSERR_BIT  = 65;

    typedef logic [LNRV_IBUF_ENTRY_W-1:0] ibuf_entry_t;

    function automatic ibuf_entry_t ibuf_pack(input logic [31:0] pc,
                                              input logic [31:0] ir,
                                              input logic        misalgn,
                                              input logic        buserr);
        ibuf_entry_t e;
        e = '0;
        e[LNRV_IBUF_PC_LSB +: 32]      = pc;
        e[LNRV_IBUF_IR_LSB +: 32]      = ir;
        e[LNRV_IBUF_MISALGN_BIT]       = misalgn;
        e[LNRV_IBUF_BUSERR_BIT]        = buserr;
        return e;
    endfunction

endpackage

// File: rtl/lnrv_gnrl_fifo.sv
// Generic width/depth synchronous FIFO with synchronous clear; the caller is
// responsible for never pushing when full or popping when empty.
module lnrv_gnrl_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [PTR_W:0]   cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_i && !pop_i)      cnt_d = cnt_q + CNT_ONE;
            else if (!push_i && pop_i) cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is cleared on reset so the read port never shows X.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/lnrv_ifu_ibuf.sv
// IFU instruction queue between fetch and decode. Define
// LNRV_IFU_IBUF_BYPASS_EN to forward fetch packets straight to decode when empty.
module lnrv_ifu_ibuf
    import lnrv_ifu_ibuf_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           flush_i,
    input  logic           ifu_ir_vld_i,
    output logic           ifu_ir_rdy_o,
    input  logic [31:0]    ifu_pc_i,
    input  logic [31:0]    ifu_ir_i,
    input  logic           ifu_misalgn_i,
    input  logic           ifu_buserr_i,
    output logic           dec_ir_vld_o,
    input  logic           dec_ir_rdy_i,
    output logic [31:0]    dec_pc_o,
    output logic [31:0]    dec_ir_o,
    output logic           dec_misalgn_o,
    output logic           dec_buserr_o,
    output logic [PTR_W:0] ibuf_cnt_o
);

    ibuf_entry_t fifo_wdata;
    ibuf_entry_t fifo_rdata;
    ibuf_entry_t dec_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic        push;
    logic        pop;

    assign fifo_wdata = ibuf_pack(ifu_pc_i, ifu_ir_i, ifu_misalgn_i, ifu_buserr_i);

    // Ready comes only from registered occupancy, so decode stall never
    // reaches the fetch bus combinationally.
    assign ifu_ir_rdy_o = ~fifo_full & ~flush_i & ~reset_i;
    assign push         = ifu_ir_vld_i & ifu_ir_rdy_o;
    assign pop          = dec_ir_vld_o & dec_ir_rdy_i;

`ifdef LNRV_IFU_IBUF_BYPASS_EN
    logic bypass;

    // An empty queue hands the incoming packet straight to decode; it is
    // only stored if decode does not take it this cycle.
    assign bypass       = fifo_empty & ifu_ir_vld_i & ~flush_i & ~reset_i;
    assign dec_ir_vld_o = (~fifo_empty | bypass) & ~flush_i;
    assign dec_entry    = bypass ? fifo_wdata : fifo_rdata;
    assign fifo_push    = push & ~(bypass & dec_ir_rdy_i);
    assign fifo_pop     = pop & ~fifo_empty;
`else
    assign dec_ir_vld_o = ~fifo_empty & ~flush_i;
    assign dec_entry    = fifo_rdata;
    assign fifo_push    = push;
    assign fifo_pop     = pop;
`endif

    lnrv_gnrl_fifo #(
        .WIDTH (LNRV_IBUF_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .cnt_o   (ibuf_cnt_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign dec_pc_o      = dec_entry[LNRV_IBUF_PC_LSB +: 32];
    assign dec_ir_o      = dec_entry[LNRV_IBUF_IR_LSB +: 32];
    assign dec_misalgn_o = dec_entry[LNRV_IBUF_MISALGN_BIT];
    assign dec_buserr_o  = dec_entry[LNRV_IBUF_BUSERR_BIT];

endmodule
